// File: rtl/duck_pkg.sv
// Shared duck-hunt types and screen geometry. The game logic and the draw
// stage use the same sprite/screen constants.
package duck_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLYING  = 3'd1,
    FALLING = 3'd2,
    ESCAPE  = 3'd3,
    RESPAWN = 3'd4
  } duck_state_e;

  localparam int DUCK_W   = 96;
  localparam int DUCK_H   = 60;
  localparam int SCREEN_W = 1024;
  localparam int GROUND_Y = 600;

  // Top-left limits that keep the whole sprite on screen, above the grass.
  localparam int X_MAX = SCREEN_W - DUCK_W;
  localparam int Y_MAX = GROUND_Y - DUCK_H;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/duck_motion_tick_gen.sv
// Movement tick divider: one-cycle tick every TICK_DIV enabled clocks.
module move_tick_gen #(
  parameter int TICK_DIV = 650_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..TICK_DIV-1 while enabled; clear restarts the phase.
  always_ff @(posedge clk) begin
    if (rst || clear)  r_cnt <= '0;
    else if (enable)   r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
  end

  assign tick = enable && (r_cnt == C_LAST);

endmodule

// File: rtl/duck_motion_ctl.sv
// Duck motion controller: flies with wall bounce, falls when shot, escapes
// upward after a timeout, then respawns at a pseudo-random x.
module duck_motion_ctl
  import duck_pkg::*;
#(
  parameter int          TICK_DIV   = 650_000,
  parameter int          SPEED      = 4,
  parameter int          FALL_SPEED = 8,
  parameter int          FLY_TICKS  = 500,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hunt_start,
  input  logic        duck_hit,
  output logic [11:0] duck_xpos,
  output logic [11:0] duck_ypos,
  output logic        duck_dir_left,
  output logic        duck_falling,
  output logic        duck_visible,
  output logic        duck_escaped
);

  localparam logic [11:0] C_XMAX = 12'(X_MAX);
  localparam logic [11:0] C_YMAX = 12'(Y_MAX);
  localparam logic [11:0] C_GND  = 12'(GROUND_Y);
  localparam logic [11:0] C_SPD  = 12'(SPEED);
  localparam logic [11:0] C_FSPD = 12'(FALL_SPEED);
  localparam int          FCW    = (FLY_TICKS > 0) ? $clog2(FLY_TICKS + 1) : 1;
  localparam logic [FCW-1:0] C_FLY_LAST = FCW'(FLY_TICKS);

  duck_state_e    r_state, w_next;
  logic [11:0]    r_x, r_y, w_x, w_y, w_spawn_x;
  logic           r_left, w_left, r_down, w_down;
  logic           r_fall, r_vis, r_esc, w_esc;
  logic [FCW-1:0] r_fc, w_fc;
  logic [15:0]    r_lfsr;
  logic           w_tick, w_tick_en, w_tick_clr;
  logic           w_fall_done, w_esc_done, w_fly_done;

  // Tick runs whenever the duck is active; its phase restarts at launch.
  assign w_tick_en  = (r_state != IDLE);
  assign w_tick_clr = (r_state == IDLE) && hunt_start;

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (w_tick_en),
    .clear  (w_tick_clr),
    .tick   (w_tick)
  );

  assign w_fall_done = (r_y + C_FSPD) >= C_GND;
  assign w_esc_done  = (r_y <= C_SPD);
  assign w_fly_done  = (r_fc == C_FLY_LAST);
  // lfsr[9:0] spans 0..1023; fold the off-screen band back by 512.
  assign w_spawn_x   = ({2'b00, r_lfsr[9:0]} > C_XMAX) ? {2'b00, r_lfsr[9:0]} - 12'd512
                                                       : {2'b00, r_lfsr[9:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a hit outranks the escape timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (hunt_start) w_next = FLYING;
      FLYING:  if (duck_hit) w_next = FALLING;
               else if (w_fly_done) w_next = ESCAPE;
      FALLING: if (w_tick && w_fall_done) w_next = RESPAWN;
      ESCAPE:  if (w_tick && w_esc_done) w_next = RESPAWN;
      RESPAWN: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath next values; bounces clamp on the same tick so nothing wraps.
  always_comb begin
    w_x    = r_x;
    w_y    = r_y;
    w_left = r_left;
    w_down = r_down;
    w_fc   = r_fc;
    w_esc  = 1'b0;
    case (r_state)
      FLYING: begin
        if (duck_hit) begin
          w_fc = '0;
        end else if (w_fly_done) begin
          w_down = 1'b0;
        end else if (w_tick && hunt_start) begin
          if (r_left) begin
            if (r_x <= C_SPD) begin w_x = '0; w_left = 1'b0; end
            else w_x = r_x - C_SPD;
          end else begin
            if ((r_x + C_SPD) >= C_XMAX) begin w_x = C_XMAX; w_left = 1'b1; end
            else w_x = r_x + C_SPD;
          end
          if (r_down) begin
            if ((r_y + C_SPD) >= C_YMAX) begin w_y = C_YMAX; w_down = 1'b0; end
            else w_y = r_y + C_SPD;
          end else begin
            if (r_y <= C_SPD) begin w_y = '0; w_down = 1'b1; end
            else w_y = r_y - C_SPD;
          end
          w_fc = r_fc + 1'b1;
        end
      end
      FALLING: if (w_tick && !w_fall_done) w_y = r_y + C_FSPD;
      ESCAPE: begin
        w_down = 1'b0;
        if (w_tick) begin
          if (w_esc_done) w_esc = 1'b1;
          else            w_y   = r_y - C_SPD;
        end
      end
      RESPAWN: begin
        w_x    = w_spawn_x;
        w_y    = C_YMAX;
        w_left = r_lfsr[10];
        w_down = 1'b0;
        w_fc   = '0;
      end
      default: ;
    endcase
  end

  // Registered position, direction and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= C_YMAX;
      r_left <= 1'b0;
      r_down <= 1'b0;
      r_fc   <= '0;
      r_fall <= 1'b0;
      r_vis  <= 1'b0;
      r_esc  <= 1'b0;
    end else begin
      r_x    <= w_x;
      r_y    <= w_y;
      r_left <= w_left;
      r_down <= w_down;
      r_fc   <= w_fc;
      r_fall <= (w_next == FALLING);
      r_vis  <= (w_next == FLYING) || (w_next == FALLING) || (w_next == ESCAPE);
      r_esc  <= w_esc;
    end
  end

  // Free-running LFSR for respawn x and direction.
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= LFSR_SEED;
    else     r_lfsr <= lfsr_step(r_lfsr);
  end

  assign duck_xpos     = r_x;
  assign duck_ypos     = r_y;
  assign duck_dir_left = r_left;
  assign duck_falling  = r_fall;
  assign duck_visible  = r_vis;
  assign duck_escaped  = r_esc;

endmodule

// File: tb/tb_duck_motion_ctl.sv
// Bench for duck_motion_ctl: cycle scoreboard plus directed boundary checks.
module tb_duck_motion_ctl;

  localparam int TD = 4, SPD = 4, FS = 8, FT = 300;
  localparam int XMAX = 928, YMAX = 540, GY = 600;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, hunt_start, duck_hit;
  logic [11:0] duck_xpos, duck_ypos;
  logic        duck_dir_left, duck_falling, duck_visible, duck_escaped;

  int checks = 0, failures = 0;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        l;
    logic        f;
    logic        v;
    logic        e;
  } exp_t;
  exp_t sbq[$];

  // Reference model state (0 idle, 1 fly, 2 fall, 3 escape, 4 respawn).
  int          m_st, m_x, m_y, m_tc, m_fc;
  bit          m_l, m_dn;
  logic [15:0] m_lfsr;
  int          esc_cnt, max_x, last_fy, last_fx;

  duck_motion_ctl #(
    .TICK_DIV(TD), .SPEED(SPD), .FALL_SPEED(FS), .FLY_TICKS(FT), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .hunt_start(hunt_start), .duck_hit(duck_hit),
    .duck_xpos(duck_xpos), .duck_ypos(duck_ypos), .duck_dir_left(duck_dir_left),
    .duck_falling(duck_falling), .duck_visible(duck_visible), .duck_escaped(duck_escaped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    exp_t e;
    int   ns;
    bit   tick, esc;
    esc = 0;
    if (rst) begin
      m_st = 0; m_x = 0; m_y = YMAX; m_l = 0; m_dn = 0;
      m_tc = 0; m_fc = 0; m_lfsr = SEED;
    end else begin
      tick = (m_st != 0) && (m_tc == TD - 1);
      ns   = m_st;
      case (m_st)
        0: if (hunt_start) ns = 1;
        1: begin
          if (duck_hit) begin ns = 2; m_fc = 0; end
          else if (m_fc == FT) begin ns = 3; m_dn = 0; end
          else if (tick && hunt_start) begin
            if (m_l) begin
              if (m_x <= SPD) begin m_x = 0; m_l = 0; end else m_x -= SPD;
            end else begin
              if (m_x + SPD >= XMAX) begin m_x = XMAX; m_l = 1; end else m_x += SPD;
            end
            if (m_dn) begin
              if (m_y + SPD >= YMAX) begin m_y = YMAX; m_dn = 0; end else m_y += SPD;
            end else begin
              if (m_y <= SPD) begin m_y = 0; m_dn = 1; end else m_y -= SPD;
            end
            m_fc++;
          end
        end
        2: if (tick) begin
          if (m_y + FS >= GY) ns = 4; else m_y += FS;
        end
        3: if (tick) begin
          if (m_y <= SPD) begin esc = 1; ns = 4; end else m_y -= SPD;
        end
        default: begin
          m_x = int'(m_lfsr & 16'h03FF);
          if (m_x > XMAX) m_x -= 512;
          m_y = YMAX; m_l = m_lfsr[10]; m_dn = 0; m_fc = 0; ns = 0;
        end
      endcase
      if (m_st == 0) begin
        if (hunt_start) m_tc = 0;
      end else begin
        m_tc = (m_tc + 1) % TD;
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_st = ns;
    end
    e.x = 12'(m_x);
    e.y = 12'(m_y);
    e.l = m_l;
    e.f = (m_st == 2);
    e.v = (m_st == 1) || (m_st == 2) || (m_st == 3);
    e.e = esc;
    sbq.push_back(e);
  endtask

  // One clock: predict, clock, then compare away from the edge.
  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_xpos",    duck_xpos,     e.x);
    chk("sb_ypos",    duck_ypos,     e.y);
    chk("sb_dirleft", duck_dir_left, e.l);
    chk("sb_falling", duck_falling,  e.f);
    chk("sb_visible", duck_visible,  e.v);
    chk("sb_escaped", duck_escaped,  e.e);
    if (duck_escaped === 1'b1) esc_cnt++;
    if (int'(duck_xpos) > max_x) max_x = int'(duck_xpos);
    if (duck_falling === 1'b1) begin
      last_fy = int'(duck_ypos);
      last_fx = int'(duck_xpos);
    end
  endtask

  task automatic run_fc(input int n);
    int b = 0;
    while (m_fc != n && b < 3000) begin cyc(); b++; end
    chk("reach_fly_cnt", m_fc, n);
  endtask

  task automatic run_idle();
    int b = 0;
    while (m_st != 0 && b < 3000) begin cyc(); b++; end
    chk("reach_idle", m_st, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; hunt_start = 1'b0; duck_hit = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    esc_cnt = 0; max_x = 0; last_fy = -1; last_fx = -1;
  endtask

  initial begin
    rst = 1'b1; hunt_start = 1'b0; duck_hit = 1'b0;

    // Reset state, launch, first tick, freeze, right wall, escape.
    do_reset();
    chk("rst_xpos", duck_xpos, 0);
    chk("rst_ypos", duck_ypos, 540);
    chk("rst_dir", duck_dir_left, 0);
    chk("rst_visible", duck_visible, 0);
    hunt_start = 1'b1;
    cyc();
    chk("visible_rise", duck_visible, 1);
    chk("launch_pos_x", duck_xpos, 0);
    run_fc(1);
    chk("tick1_x", duck_xpos, 4);
    chk("tick1_y", duck_ypos, 536);
    chk("tick1_dir", duck_dir_left, 0);
    hunt_start = 1'b0;
    repeat (40) cyc();
    chk("freeze_x", duck_xpos, 4);
    chk("freeze_y", duck_ypos, 536);
    hunt_start = 1'b1;
    run_fc(232);
    chk("wall_x", duck_xpos, 928);
    chk("wall_dir", duck_dir_left, 1);
    run_fc(233);
    chk("wall_back_x", duck_xpos, 924);
    run_fc(FT);
    hunt_start = 1'b0;
    run_idle();
    chk("x_never_past_max", max_x <= XMAX, 1);
    chk("escaped_pulses", esc_cnt, 1);
    chk("esc_respawn_vis", duck_visible, 0);
    chk("esc_respawn_y", duck_ypos, 540);
    chk("esc_respawn_x_rng", duck_xpos <= 12'd928, 1);
    repeat (20) cyc();
    chk("idle_wait_vis", duck_visible, 0);

    // Shot at y=300: fall in 8 px steps to the grass, then respawn.
    do_reset();
    hunt_start = 1'b1;
    run_fc(60);
    chk("pre_hit_y", duck_ypos, 300);
    duck_hit = 1'b1; hunt_start = 1'b0;
    cyc();
    duck_hit = 1'b0;
    chk("hit_falling", duck_falling, 1);
    chk("hit_freeze_x", duck_xpos, 240);
    chk("hit_freeze_y", duck_ypos, 300);
    run_idle();
    chk("fall_last_y", last_fy, 596);
    chk("fall_fixed_x", last_fx, 240);
    chk("fall_respawn_vis", duck_visible, 0);
    chk("fall_respawn_y", duck_ypos, 540);
    chk("fall_respawn_x_rng", duck_xpos <= 12'd928, 1);
    chk("fall_no_escape", esc_cnt, 0);
    repeat (20) cyc();
    chk("idle_hold_vis", duck_visible, 0);

    // Hit on the timeout cycle wins; then reset in the middle of the fall.
    do_reset();
    hunt_start = 1'b1;
    run_fc(FT);
    duck_hit = 1'b1;
    cyc();
    duck_hit = 1'b0; hunt_start = 1'b0;
    chk("tie_falling", duck_falling, 1);
    chk("tie_y", duck_ypos, 420);
    repeat (10) cyc();
    chk("tie_still_falling", duck_falling, 1);
    chk("tie_no_escape", esc_cnt, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_xpos", duck_xpos, 0);
    chk("midrst_ypos", duck_ypos, 540);
    chk("midrst_dir", duck_dir_left, 0);
    chk("midrst_falling", duck_falling, 0);
    chk("midrst_visible", duck_visible, 0);
    chk("midrst_escaped", duck_escaped, 0);
    repeat (12) cyc();
    chk("midrst_idle_vis", duck_visible, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
